// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, FSM encoding, rho offsets and lane helpers for Keccak-f[1600]
package keccak_pkg;
   localparam int STATE_W = 1600;
   localparam int LANE_W = 64;
   localparam int NROUNDS_DEF = 24;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;
   localparam int RHO [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                               41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
   function automatic int lane_idx(input int x, input int y);
      return LANE_W * (x + 5 * y);
   endfunction
   function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
      return n == 0 ? v : (v << n) | (v >> (LANE_W - n));
   endfunction
endpackage

// File: rtl/keccak_round.sv
// keccak_round: one combinational Keccak-f[1600] round (theta, rho, pi, chi, iota)
module keccak_round
   import keccak_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [6:0]         rc,
   output logic [STATE_W-1:0] next_state
);
   logic [LANE_W-1:0] a [25];
   logic [LANE_W-1:0] b [25];
   logic [LANE_W-1:0] c [5];
   logic [LANE_W-1:0] d [5];
   always_comb begin
      b = '{default: '0};
      next_state = '0;
      for (int i = 0; i < 25; i++) a[i] = state[LANE_W*i +: LANE_W];
      for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
      for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            b[y + 5*((2*x + 3*y) % 5)] = rotl(a[x+5*y] ^ d[x], RHO[x+5*y]);
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            next_state[lane_idx(x, y) +: LANE_W] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
      // iota: rc bit j lands on lane (0,0) bit 2^j-1
      for (int j = 0; j < 7; j++) next_state[(1 << j) - 1] ^= rc[j];
   end
endmodule

// File: rtl/keccak_f_ctrl.sv
// keccak_f_ctrl: iterative Keccak-f[1600] permutation, one round per clock
module keccak_f_ctrl
   import keccak_pkg::*;
#(
   parameter int NROUNDS = NROUNDS_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic               busy,
   output logic [4:0]         round_idx,
   output logic [6:0]         rc
);
   fsm_t               st;
   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_nxt;
   logic [4:0]         rnd;
   logic [7:0]         lfsr;
   logic [7:0]         lfsr_nxt;
   logic [6:0]         rc_raw;
   logic               run;
   logic               last;
   logic               accept;
   // seven LFSR steps per round; bit 0 of each intermediate value is one rc bit
   always_comb begin
      lfsr_nxt = lfsr;
      rc_raw = '0;
      for (int j = 0; j < 7; j++) begin
         rc_raw[j] = lfsr_nxt[0];
         lfsr_nxt = {lfsr_nxt[6:0], 1'b0} ^ (lfsr_nxt[7] ? 8'h71 : 8'h00);
      end
   end
   assign run       = st == RUN;
   assign last      = rnd == 5'(NROUNDS - 1);
   assign accept    = st == IDLE && in_valid;
   assign in_ready  = st == IDLE;
   assign out_valid = st == DONE;
   assign busy      = run;
   assign round_idx = run ? rnd : '0;
   assign rc        = run ? rc_raw : '0;
   assign out_state = state_q;
   keccak_round u_round (
      .state      (state_q),
      .rc         (rc_raw),
      .next_state (state_nxt)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st      <= IDLE;
         state_q <= '0;
         rnd     <= '0;
         lfsr    <= 8'h01;
      end else begin
         st      <= accept ? RUN : run ? (last ? DONE : RUN) : (out_valid && out_ready) ? IDLE : st;
         state_q <= accept ? in_state : run ? state_nxt : state_q;
         rnd     <= (run && !last) ? rnd + 5'd1 : '0;
         lfsr    <= run ? lfsr_nxt : 8'h01;
      end
   end
endmodule

// File: tb/tb_keccak_f_ctrl.sv
// tb_keccak_f_ctrl: scoreboard bench for keccak_f_ctrl against an independent Keccak-f[1600] model
module tb_keccak_f_ctrl;
   logic          clk = 0;
   logic          rst = 1;
   logic          in_valid = 0;
   logic          out_ready = 0;
   logic [1599:0] in_state = '0;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic [1599:0] out_state;
   logic [4:0]    round_idx;
   logic [6:0]    rc;
   int            vecs = 0;
   int            errs = 0;
   int            cyc = 0;
   logic [1599:0] q [$];

   keccak_f_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy),
      .round_idx (round_idx),
      .rc        (rc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] rot(input logic [63:0] v, input int n);
      int k;
      k = n % 64;
      return k == 0 ? v : (v << k) | (v >> (64 - k));
   endfunction

   // FIPS 202 rc(t), computed from scratch for every bit
   function automatic logic rcbit(input int t);
      logic [8:0] r9;
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < t % 255; i++) begin
         r9 = {r, 1'b0};
         r9[0] ^= r9[8];
         r9[4] ^= r9[8];
         r9[5] ^= r9[8];
         r9[6] ^= r9[8];
         r = r9[7:0];
      end
      return r[0];
   endfunction

   function automatic logic [6:0] rc_ref(input int rnd);
      logic [6:0] v;
      for (int j = 0; j < 7; j++) v[j] = rcbit(j + 7 * rnd);
      return v;
   endfunction

   function automatic logic [1599:0] kf(input logic [1599:0] s);
      logic [63:0]   a [5][5];
      logic [63:0]   bb [5][5];
      logic [63:0]   c [5];
      logic [1599:0] o;
      int            px, py, nx;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) a[i][j] = s[64*(i+5*j) +: 64];
      for (int r = 0; r < 24; r++) begin
         for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) a[i][j] ^= c[(i+4)%5] ^ rot(c[(i+1)%5], 1);
         px = 1;
         py = 0;
         for (int t = 0; t < 24; t++) begin
            a[px][py] = rot(a[px][py], ((t + 1) * (t + 2) / 2) % 64);
            nx = py;
            py = (2 * px + 3 * py) % 5;
            px = nx;
         end
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) bb[j][(2*i + 3*j) % 5] = a[i][j];
         for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) a[i][j] = bb[i][j] ^ (~bb[(i+1)%5][j] & bb[(i+2)%5][j]);
         for (int j = 0; j < 7; j++) a[0][0][(1 << j) - 1] ^= rcbit(j + 7 * r);
      end
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) o[64*(i+5*j) +: 64] = a[i][j];
      return o;
   endfunction

   function automatic logic [1599:0] rand_state();
      logic [1599:0] s;
      for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, want %h", n, act, exp);
      end
   endtask

   task automatic chk_state(input string n, input logic [1599:0] act, input logic [1599:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         for (int i = 0; i < 25; i++)
            if (act[64*i +: 64] !== exp[64*i +: 64]) begin
               $display("FAIL %s lane %0d: got %h, want %h", n, i, act[64*i +: 64], exp[64*i +: 64]);
               break;
            end
      end
   endtask

   // call #1 after a rising edge; returns #1 after the accepting edge
   task automatic send(input logic [1599:0] s, input bit keep, output int waited);
      in_state = s;
      in_valid = 1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         vecs++;
         errs++;
         $display("FAIL send: in_ready low for %0d cycles", waited);
         in_valid = 0;
      end else begin
         q.push_back(kf(s));
         @(posedge clk);
         #1;
         if (!keep) in_valid = 0;
      end
   endtask

   task automatic wait_ov();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      vecs++;
      errs++;
      $display("FAIL wait_ov: out_valid never rose");
   endtask

   // monitor: round sequence, latency, and scoreboard pop on output handshake
   initial begin
      int   exp_rnd;
      int   acc_cyc;
      logic ov_prev;
      exp_rnd = 0;
      acc_cyc = 0;
      ov_prev = 0;
      forever begin
         @(negedge clk);
         if (busy) begin
            chk("round_idx", 64'(round_idx), 64'(exp_rnd));
            chk("rc", 64'(rc), 64'(rc_ref(exp_rnd)));
            if (exp_rnd == 0) chk("rc round0", 64'(rc), 64'h01);
            if (exp_rnd == 1) chk("rc round1", 64'(rc), 64'h1A);
            if (exp_rnd == 23) chk("rc round23", 64'(rc), 64'h74);
            exp_rnd++;
         end else begin
            exp_rnd = 0;
            chk("idle round_idx", 64'(round_idx), 64'd0);
            chk("idle rc", 64'(rc), 64'd0);
         end
         if (in_valid && in_ready && rst) acc_cyc = cyc + 1;
         if (out_valid && !ov_prev) chk("latency", 64'(cyc - acc_cyc), 64'd24);
         ov_prev = out_valid;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               vecs++;
               errs++;
               $display("FAIL scoreboard: output with no expected entry");
            end else chk_state("out_state", out_state, q.pop_front());
         end
      end
   end

   initial begin
      logic [1599:0] snap;
      logic [1599:0] pats [4];
      int            w;
      int            t [4];
      #2 rst = 0;
      #1;
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset round_idx", 64'(round_idx), 64'd0);
      chk("reset rc", 64'(rc), 64'd0);
      chk_state("reset out_state", out_state, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1;

      out_ready = 1;
      send('0, 0, w);
      wait_ov();
      chk("zero lane00", out_state[63:0], 64'hF1258F7940E1DDE7);
      @(posedge clk);
      #1;

      out_ready = 0;
      send(rand_state(), 0, w);
      wait_ov();
      snap = out_state;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = ~in_valid;
         in_state = rand_state();
         @(negedge clk);
         chk_state("hold out_state", out_state, snap);
         chk("hold in_ready", 64'(in_ready), 64'd0);
         chk("hold out_valid", 64'(out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      out_ready = 1;
      @(posedge clk);
      #1;
      chk("release in_ready", 64'(in_ready), 64'd1);
      chk("release out_valid", 64'(out_valid), 64'd0);

      send(rand_state(), 0, w);
      w = 0;
      while (!(busy && round_idx == 5'd12) && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("reached round 12", 64'(round_idx), 64'd12);
      #2 rst = 0;
      #1;
      chk("abort in_ready", 64'(in_ready), 64'd1);
      chk("abort out_valid", 64'(out_valid), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort round_idx", 64'(round_idx), 64'd0);
      chk("abort rc", 64'(rc), 64'd0);
      chk_state("abort out_state", out_state, '0);
      q.delete();
      @(posedge clk);
      #1 rst = 1;
      send('0, 0, w);
      chk("accept on first edge", 64'(w), 64'd0);
      wait_ov();
      chk("zero lane00 after abort", out_state[63:0], 64'hF1258F7940E1DDE7);
      @(posedge clk);
      #1;

      pats[0] = '1;
      pats[1] = {25{64'hA5A5_5A5A_0F0F_F0F0}};
      for (int i = 0; i < 25; i++) pats[2][64*i +: 64] = 64'h1 << (i * 2 + 1);
      pats[3] = rand_state();
      for (int i = 0; i < 4; i++) begin
         send(pats[i], 1, w);
         t[i] = cyc;
         if (i > 0) chk("b2b spacing", 64'(t[i] - t[i-1]), 64'd26);
      end
      in_valid = 0;

      for (int i = 0; i < 6; i++) send(rand_state(), 0, w);

      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/keccak_f_ctrl.md
KECCAK_F_CTRL -- requirements
Module: keccak_f_ctrl

Interface
REQ-001 SHALL have parameter NROUNDS, default 24, meaning rounds per permutation (legal values 1..24; only 24 is a valid Keccak-f[1600]).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input state present.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port in_state  input  1600  state; lane (x,y) at bits [64*(x+5y)+63 : 64*(x+5y)], little-endian within each lane.
REQ-007 SHALL have port out_valid  output  1  permuted state available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_state.
REQ-009 SHALL have port out_state  output  1600  permuted state, same layout as in_state.
REQ-010 SHALL have port busy  output  1  high while rounds execute.
REQ-011 SHALL have port round_idx  output  5  index of the round applied on the current RUN cycle, 0..NROUNDS-1.
REQ-012 SHALL have port rc  output  7  compressed round constant for the current round; bit j XORs lane (0,0) bit 2^j-1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, SHALL load in_state into the state register, clear round_idx, load the LFSR with 8'h01 and go to RUN.
REQ-015 RUN: each cycle SHALL replace the state register with round(state, rc) (theta, rho, pi, chi, iota) and increment round_idx.
REQ-016 On the RUN cycle with round_idx==NROUNDS-1, SHALL go to DONE after applying that round.
REQ-017 DONE: out_valid=1; out_state SHALL equal the state register and stay stable until out_ready; on out_ready SHALL go to IDLE.
REQ-018 Latency: out_valid SHALL rise exactly NROUNDS cycles after the accepting edge (24 for the default).
REQ-019 in_valid SHALL be ignored in RUN and DONE; in_ready SHALL be 0 there; no input is buffered.
REQ-020 SHALL generate rc with an 8-bit LFSR (polynomial x^8+x^6+x^5+x^4+1), advanced 7 steps combinationally per round; rc bit j = LFSR output at step 7*round+j.
REQ-021 rc values SHALL be: round 0 -> 7'h01, round 1 -> 7'h1A, round 23 -> 7'h74.
REQ-022 busy SHALL be high only in RUN; round_idx and rc SHALL hold 0 outside RUN.
REQ-023 out_valid and out_ready both high on the DONE cycle: transfer completes and the FSM reaches IDLE the next cycle; a new input is accepted no earlier than that IDLE cycle.
REQ-024 out_state outside DONE is don't-care, but SHALL not be driven X after reset.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, state register 0, round_idx 0, LFSR 8'h01, in_ready 1, out_valid 0, busy 0, rc 0.
REQ-026 Reset during RUN or DONE SHALL abort the permutation; the partial result is discarded and never presented.
REQ-027 After rst rises, the first in_valid SHALL be accepted on the first clock edge.

Structure
REQ-028 Shared package keccak_pkg SHALL hold the state width (1600), lane width (64), NROUNDS default, FSM state enum, rho offset table, and the lane index function 64*(x+5y).
REQ-029 Round logic SHALL be a combinational sub-module keccak_round (inputs state, rc; output next state); iota uses only the 7 rc bit positions.
REQ-030 The controller, LFSR and state register SHALL live in keccak_f_ctrl.

Verification
REQ-031 Zero state in, out_ready=1 -> out_valid exactly 24 cycles after acceptance; out_state lane (0,0) = 64'hF1258F7940E1DDE7.
REQ-032 Monitor rc during RUN -> round 0 = 7'h01, round 1 = 7'h1A, round 23 = 7'h74; round_idx 0..23 in order.
REQ-033 Hold out_ready=0 for 10 cycles in DONE, toggle in_valid -> out_state stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-034 rst low at round_idx=12 -> all outputs at reset values immediately; next zero-state input yields the REQ-031 result.
REQ-035 Back-to-back: in_valid held high, out_ready=1 -> acceptances spaced 26 cycles (accept, 24 RUN cycles, DONE), each result correct.
REQ-036 Random states vs. software Keccak-f[1600] model (1000 vectors) -> bit-exact out_state.
